ras_ckpt: RTL and testbench

RAS_CKPT -- requirements
Module: ras_ckpt

---
 rtl/ras_ckpt.sv | 171 +++++++++++++++++
 tb/tb_ras_ckpt.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ras_ckpt.sv
// rtl/ras_ckpt.sv - return address stack with checkpoint/restore for misprediction recovery
//
// Purpose:
//   Circular return address stack with a wrapping tos pointer and a valid-entry
//   count. Each checkpoint slot holds {tos, count, entry at tos}. Restoring a slot
//   brings back tos and count and repairs the one entry that speculative
//   push+pop could have overwritten.
//
// Configuration:
//   RAS_OVERFLOW_WRAP_EN - when defined, a push on a full stack overwrites the
//                          oldest entry. When undefined, that push is dropped.
//                          Both cases pulse overflow_o.
//
// Ports:
//   clk, rst             - clock (rising edge), synchronous active-high reset
//   push_i, push_pc_i    - call: push a return address
//   pop_i                - return: pop the top entry
//   flush_i              - empty the stack
//   ckpt_save_i, ckpt_id_i     - save the post-update state into a slot
//   restore_i, restore_id_i    - restore state from a slot
//   top_pc_o, valid_o, count_o - registered-state view of the stack
//   overflow_o, underflow_o    - one-cycle pulses, the cycle after the event

module ras_ckpt #(
    parameter int PC_BITS   = 32,
    parameter int RAS_DEPTH = 8,
    parameter int CKPT_NUM  = 8,
    localparam int CW       = $clog2(CKPT_NUM),
    localparam int TW       = $clog2(RAS_DEPTH),
    localparam int CNTW     = $clog2(RAS_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push_i,
    input  logic [PC_BITS-1:0] push_pc_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  logic               ckpt_save_i,
    input  logic [CW-1:0]      ckpt_id_i,
    input  logic               restore_i,
    input  logic [CW-1:0]      restore_id_i,
    output logic [PC_BITS-1:0] top_pc_o,
    output logic               valid_o,
    output logic [CNTW-1:0]    count_o,
    output logic               overflow_o,
    output logic               underflow_o
);

    logic [PC_BITS-1:0] r_stack [RAS_DEPTH];
    logic [TW-1:0]      r_tos;
    logic [CNTW-1:0]    r_count;
    logic               r_overflow;
    logic               r_underflow;

    logic [TW-1:0]      r_ck_tos [CKPT_NUM];
    logic [CNTW-1:0]    r_ck_cnt [CKPT_NUM];
    logic [PC_BITS-1:0] r_ck_pc  [CKPT_NUM];

    logic [TW-1:0]      w_tos_nxt;
    logic [CNTW-1:0]    w_cnt_nxt;
    logic               w_wr_en;
    logic [TW-1:0]      w_wr_idx;
    logic [PC_BITS-1:0] w_wr_data;
    logic               w_ovf;
    logic               w_unf;
    logic               w_full;
    logic               w_empty;
    logic [TW-1:0]      w_tos_inc;
    logic [TW-1:0]      w_tos_dec;
    logic [PC_BITS-1:0] w_top_nxt;

    assign w_full    = (r_count == CNTW'(RAS_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_tos_inc = r_tos + TW'(1);
    assign w_tos_dec = r_tos - TW'(1);

    always_comb begin
        w_tos_nxt = r_tos;
        w_cnt_nxt = r_count;
        w_wr_en   = 1'b0;
        w_wr_idx  = r_tos;
        w_wr_data = push_pc_i;
        w_ovf     = 1'b0;
        w_unf     = 1'b0;
        if (flush_i) begin
            w_tos_nxt = '0;
            w_cnt_nxt = '0;
        end else if (restore_i) begin
            // Rewrite the saved top entry: speculative push+pop may have clobbered it.
            w_tos_nxt = r_ck_tos[restore_id_i];
            w_cnt_nxt = r_ck_cnt[restore_id_i];
            w_wr_en   = 1'b1;
            w_wr_idx  = r_ck_tos[restore_id_i];
            w_wr_data = r_ck_pc[restore_id_i];
        end else if (push_i && pop_i) begin
            if (w_empty) begin
                w_tos_nxt = w_tos_inc;
                w_cnt_nxt = CNTW'(1);
                w_wr_en   = 1'b1;
                w_wr_idx  = w_tos_inc;
            end else begin
                w_wr_en   = 1'b1;
                w_wr_idx  = r_tos;
            end
        end else if (push_i) begin
            if (!w_full) begin
                w_tos_nxt = w_tos_inc;
                w_cnt_nxt = r_count + CNTW'(1);
                w_wr_en   = 1'b1;
                w_wr_idx  = w_tos_inc;
            end else begin
                w_ovf = 1'b1;
`ifdef RAS_OVERFLOW_WRAP_EN
                // The slot after tos holds the oldest entry once full.
                w_tos_nxt = w_tos_inc;
                w_wr_en   = 1'b1;
                w_wr_idx  = w_tos_inc;
`else
`endif
            end
        end else if (pop_i) begin
            if (!w_empty) begin
                w_tos_nxt = w_tos_dec;
                w_cnt_nxt = r_count - CNTW'(1);
            end else begin
                w_unf = 1'b1;
            end
        end
    end

    // Top entry as it will look after this edge, for checkpoint capture.
    assign w_top_nxt = (w_wr_en && (w_wr_idx == w_tos_nxt)) ? w_wr_data : r_stack[w_tos_nxt];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tos       <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            for (int i = 0; i < CKPT_NUM; i++) begin
                r_ck_tos[i] <= '0;
                r_ck_cnt[i] <= '0;
                r_ck_pc[i]  <= '0;
            end
        end else begin
            r_tos       <= w_tos_nxt;
            r_count     <= w_cnt_nxt;
            r_overflow  <= w_ovf;
            r_underflow <= w_unf;
            if (ckpt_save_i) begin
                r_ck_tos[ckpt_id_i] <= w_tos_nxt;
                r_ck_cnt[ckpt_id_i] <= w_cnt_nxt;
                r_ck_pc[ckpt_id_i]  <= w_top_nxt;
            end
        end
    end

    // Entry array is not cleared by reset; count gates visibility.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_en) begin
            r_stack[w_wr_idx] <= w_wr_data;
        end
    end

    assign valid_o     = !w_empty;
    assign count_o     = r_count;
    assign top_pc_o    = w_empty ? '0 : r_stack[r_tos];
    assign overflow_o  = r_overflow;
    assign underflow_o = r_underflow;

endmodule

// File: tb/tb_ras_ckpt.sv
// tb/tb_ras_ckpt.sv - directed self-checking bench for ras_ckpt
module tb_ras_ckpt;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push_i = 1'b0;
    logic [31:0] push_pc_i = '0;
    logic        pop_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        ckpt_save_i = 1'b0;
    logic [2:0]  ckpt_id_i = '0;
    logic        restore_i = 1'b0;
    logic [2:0]  restore_id_i = '0;
    logic [31:0] top_pc_o;
    logic        valid_o;
    logic [3:0]  count_o;
    logic        overflow_o;
    logic        underflow_o;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    ras_ckpt #(.PC_BITS(32), .RAS_DEPTH(8), .CKPT_NUM(8)) dut (
        .clk(clk), .rst(rst),
        .push_i(push_i), .push_pc_i(push_pc_i), .pop_i(pop_i), .flush_i(flush_i),
        .ckpt_save_i(ckpt_save_i), .ckpt_id_i(ckpt_id_i),
        .restore_i(restore_i), .restore_id_i(restore_id_i),
        .top_pc_o(top_pc_o), .valid_o(valid_o), .count_o(count_o),
        .overflow_o(overflow_o), .underflow_o(underflow_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock with the given inputs; outputs sampled 1ns after the edge.
    task automatic cyc(input logic p, input logic [31:0] pc, input logic po, input logic fl,
                       input logic sv, input logic [2:0] sid, input logic rs, input logic [2:0] rid);
        push_i = p; push_pc_i = pc; pop_i = po; flush_i = fl;
        ckpt_save_i = sv; ckpt_id_i = sid; restore_i = rs; restore_id_i = rid;
        @(posedge clk);
        #1;
        push_i = 0; push_pc_i = '0; pop_i = 0; flush_i = 0;
        ckpt_save_i = 0; ckpt_id_i = '0; restore_i = 0; restore_id_i = '0;
    endtask

    task automatic push(input logic [31:0] pc);
        cyc(1, pc, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic pop();
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
    endtask
    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic expect_state(input string tag, input logic [31:0] top, input logic [3:0] cnt);
        chk({tag, "_top"},   top_pc_o, top);
        chk({tag, "_count"}, {28'd0, count_o}, {28'd0, cnt});
        chk({tag, "_valid"}, {31'd0, valid_o}, {31'd0, (cnt != 0)});
    endtask

    logic [31:0] exp_top;

    initial begin
        // Reset
        rst = 1'b1;
        idle();
        idle();
        rst = 1'b0;
        expect_state("reset", 32'h0, 4'd0);
        chk("reset_ovf", {31'd0, overflow_o}, 32'd0);
        chk("reset_unf", {31'd0, underflow_o}, 32'd0);

        // Basic push / pop
        push(32'h100); push(32'h200); push(32'h300);
        expect_state("push3", 32'h300, 4'd3);
        pop();  expect_state("pop1", 32'h200, 4'd2);
        pop();  expect_state("pop2", 32'h100, 4'd1);
        pop();  expect_state("pop3", 32'h0, 4'd0);

        // Underflow pulse
        pop();
        chk("unf_pulse", {31'd0, underflow_o}, 32'd1);
        chk("unf_count", {28'd0, count_o}, 32'd0);
        idle();
        chk("unf_clear", {31'd0, underflow_o}, 32'd0);

        // Push+pop on empty acts as push; push+pop non-empty replaces top
        cyc(1, 32'h55, 1, 0, 0, 0, 0, 0);
        expect_state("pp_empty", 32'h55, 4'd1);
        chk("pp_empty_unf", {31'd0, underflow_o}, 32'd0);
        cyc(1, 32'h66, 1, 0, 0, 0, 0, 0);
        expect_state("pp_replace", 32'h66, 4'd1);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        expect_state("flush", 32'h0, 4'd0);

        // Nine pushes on an 8-deep stack
        for (int i = 1; i <= 9; i++) begin
            push(32'(i * 16));
            if (i == 8) chk("ovf_at8", {31'd0, overflow_o}, 32'd0);
        end
        chk("ovf_pulse", {31'd0, overflow_o}, 32'd1);
        chk("ovf_count", {28'd0, count_o}, 32'd8);
        idle();
        chk("ovf_clear", {31'd0, overflow_o}, 32'd0);
        for (int k = 0; k < 8; k++) begin
`ifdef RAS_OVERFLOW_WRAP_EN
            exp_top = 32'h90 - 32'(16 * k);
`else
            exp_top = 32'h80 - 32'(16 * k);
`endif
            chk($sformatf("full_pop%0d", k), top_pc_o, exp_top);
            pop();
        end
        expect_state("full_drained", 32'h0, 4'd0);

        // Checkpoint / restore
        push(32'hA0);
        cyc(0, 0, 0, 0, 1, 3'd3, 0, 0);
        push(32'hB0); pop(); push(32'hC0);
        expect_state("ck_spec", 32'hC0, 4'd2);
        cyc(0, 0, 0, 0, 0, 0, 1, 3'd3);
        expect_state("ck_restore3", 32'hA0, 4'd1);
        pop();
        // Save with push in one cycle, then clobber that entry via pop+push
        cyc(1, 32'hA0, 0, 0, 1, 3'd4, 0, 0);
        pop(); push(32'hC0);
        expect_state("ck_clobber", 32'hC0, 4'd1);
        cyc(0, 0, 0, 0, 0, 0, 1, 3'd4);
        expect_state("ck_repair", 32'hA0, 4'd1);

        // Never-written slot restores to empty
        push(32'h42);
        cyc(0, 0, 0, 0, 0, 0, 1, 3'd0);
        expect_state("ck_unwritten", 32'h0, 4'd0);

        // Flush beats restore and push; same-cycle save captures the flushed state
        push(32'h1); push(32'h2); push(32'h3);
        cyc(1, 32'h4, 0, 0, 1, 3'd1, 0, 0);
        expect_state("cnt4", 32'h4, 4'd4);
        cyc(1, 32'h77, 0, 1, 1, 3'd1, 1, 3'd3);
        expect_state("flush_prio", 32'h0, 4'd0);
        cyc(0, 0, 0, 0, 0, 0, 1, 3'd1);
        expect_state("flush_saved", 32'h0, 4'd0);

        // Save and restore in one cycle: slot gets the restored state
        cyc(1, 32'h31, 0, 0, 1, 3'd6, 0, 0);
        cyc(1, 32'h32, 0, 0, 1, 3'd7, 0, 0);
        cyc(0, 0, 0, 0, 1, 3'd7, 1, 3'd6);
        expect_state("sr_same", 32'h31, 4'd1);
        push(32'h99);
        cyc(0, 0, 0, 0, 0, 0, 1, 3'd7);
        expect_state("sr_slot7", 32'h31, 4'd1);

        // Reset during push+save clears state and all slots
        cyc(1, 32'h11, 0, 0, 1, 3'd2, 0, 0);
        rst = 1'b1;
        cyc(1, 32'h22, 0, 0, 1, 3'd2, 0, 0);
        rst = 1'b0;
        expect_state("rst_push", 32'h0, 4'd0);
        cyc(0, 0, 0, 0, 0, 0, 1, 3'd2);
        expect_state("rst_slot2", 32'h0, 4'd0);
        push(32'h5);
        cyc(0, 0, 0, 0, 0, 0, 1, 3'd3);
        expect_state("rst_slot3", 32'h0, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
